lake_linebuf_ctrl: RTL and testbench
====================================

LAKE_LINEBUF_CTRL -- requirements
Module: lake_linebuf_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, pixel/SRAM data width; ADDR_W, default 16, SRAM address width; LINE_W, default 64, line delay in pixels (1..2^ADDR_W); FRAME_PIX, default 4096, pixels per frame (>= LINE_W).
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
 clk  in  1  sole clock, all state on rising edge
 flush  in  1  synchronous active-high reset
 start  in  1  frame start pulse, honoured in IDLE only
 in_valid  in  1  input pixel valid
 in_data  in  DATA_W  input pixel
 in_ready  out  1  input accepted when in_valid && in_ready
 out_valid  out  1  delayed pixel valid
 out_data  out  DATA_W  pixel delayed by LINE_W
 out_ready  in  1  downstream accept
 sram_wen  out  1  SRAM write enable
 sram_waddr  out  ADDR_W  SRAM write address
 sram_wdata  out  DATA_W  SRAM write data
 sram_ren  out  1  SRAM read enable
 sram_raddr  out  ADDR_W  SRAM read address
 sram_rdata  in  DATA_W  SRAM read data, 1-cycle latency, read-first on same-address write
 busy  out  1  state != IDLE
 done  out  1  one-cycle pulse at frame completion

Function
REQ-003 SHALL implement states IDLE, FILL, STEADY, DRAIN, DONE; IDLE->FILL on start; FILL->STEADY after LINE_W accepts; STEADY->DRAIN (LBC_DRAIN_EN) or DONE after FRAME_PIX accepts; DRAIN->DONE after LINE_W reads issued and output FIFO empty; DONE->IDLE next cycle.
REQ-004 SHALL keep write pointer wptr in 0..LINE_W-1, incrementing per accept, wrapping LINE_W-1 -> 0.
REQ-005 SHALL, per accept in FILL/STEADY, drive combinationally sram_wen=1, sram_waddr=wptr, sram_wdata=in_data.
REQ-006 SHALL, per accept in STEADY, also drive sram_ren=1, sram_raddr=wptr (same address, read-first), setting rd_pend for the next cycle; FILL issues no reads.
REQ-007 SHALL push sram_rdata into a 2-entry output FIFO in the cycle rd_pend is set; out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid && out_ready.
REQ-008 SHALL drive in_ready = 1 in FILL; in STEADY, in_ready = (count + rd_pend - pop) < 2; in_ready = 0 in IDLE, DRAIN, DONE.
REQ-009 SHALL sustain one pixel/cycle in STEADY with out_ready held 1; FIFO SHALL never overflow or lose data under any out_ready pattern.
REQ-010 SHALL ignore start outside IDLE; in_valid outside FILL/STEADY SHALL have no effect.
REQ-011 SHALL pulse done for exactly the DONE cycle; busy=1 in FILL, STEADY, DRAIN, DONE.
REQ-012 SHALL count accepted pixels with a counter wide enough for FRAME_PIX, with no wrap within a frame.
REQ-013 SHALL hold sram_wen=sram_ren=0 whenever no transfer is issued.

Reset
REQ-014 SHALL, on flush=1 at a clock edge, set state IDLE, wptr=0, pixel counter=0, rd_pend=0, FIFO empty, regardless of current state.
REQ-015 SHALL, during and after flush until next start, drive in_ready, out_valid, sram_wen, sram_ren, busy, done = 0, and addresses/data outputs = 0.
REQ-016 SHALL discard an in-flight read whose rd_pend cycle coincides with flush.

Configuration
REQ-017 SHALL compile DRAIN state iff macro LAKE_LINEBUF_CTRL_DRAIN_EN is defined: with it, after FRAME_PIX accepts, issue LINE_W reads at addresses wptr, wptr+1, ... (wrapping), one per cycle when (count + rd_pend - pop) < 2, emitting the final LINE_W pixels; without it, go STEADY->DONE once FIFO and rd_pend are empty, the last LINE_W pixels are never emitted.

Verification
REQ-018 LINE_W=4, FRAME_PIX=16, inputs 1..16 back-to-back, out_ready=1 -> waddr 0,1,2,3,0,...; first out_valid one cycle after accepting pixel 5 with out_data=1; outputs 1..12 consecutive cycles.
REQ-019 Same as REQ-018 with LAKE_LINEBUF_CTRL_DRAIN_EN -> outputs 13..16 follow; done pulses once after out_data=16 popped; total 16 outputs.
REQ-020 Same as REQ-018, out_ready toggling 1,0,1,0 -> in_ready deasserts correctly, FIFO count never exceeds 2, output sequence 1..12 in order, none dropped or duplicated.
REQ-021 LINE_W=1, FRAME_PIX=3, inputs 7,8,9 -> sram_raddr always 0; outputs 7,8 (plus 9 with drain).
REQ-022 flush asserted mid-STEADY with rd_pend=1 -> next cycle out_valid=0, busy=0, in_ready=0; new start plus inputs 1..8 (LINE_W=4) reproduce outputs from 1 with waddr restarting at 0.
REQ-023 start pulsed in STEADY -> ignored; pixel counter and wptr unaffected.

Source files
------------

// File: rtl/lake_linebuf_ctrl.sv
// Line-delay controller: writes pixels into an external SRAM ring and reads them back LINE_W later.
// Define LAKE_LINEBUF_CTRL_DRAIN_EN to add a DRAIN state that flushes the final line out of the SRAM.
module lake_linebuf_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int LINE_W    = 64,
   parameter int FRAME_PIX = 4096
) (
   input  logic              clk,
   input  logic              flush,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              sram_wen,
   output logic [ADDR_W-1:0] sram_waddr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_raddr,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(FRAME_PIX + 1);

   localparam logic [CNT_W-1:0]  C_FRAME = CNT_W'(FRAME_PIX);
   localparam logic [CNT_W-1:0]  C_LLAST = CNT_W'(LINE_W - 1);
   localparam logic [CNT_W-1:0]  C_CONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] C_WLAST = ADDR_W'(LINE_W - 1);
   localparam logic [ADDR_W-1:0] C_AONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_STEADY = 3'd2,
`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
      S_DRAIN  = 3'd3,
`endif
      S_DONE   = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_wptr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rd_pend;
   logic [DATA_W-1:0] r_fifo [2];
   logic              r_fwr;
   logic              r_frd;
   logic [1:0]        r_fcnt;
   logic              r_busy;
   logic              r_done;

   logic              w_pop;
   logic              w_push;
   logic [2:0]        w_occ;
   logic              w_room;
   logic              w_fill;
   logic              w_steady;
   logic              w_frame_end;
   logic              w_in_rdy;
   logic              w_acc;
   logic              w_rd_stdy;
   logic              w_rd_drn;
   logic              w_ren;
   logic              w_fifo_idle;
   logic [ADDR_W-1:0] w_wptr_nx;

`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
   localparam int AW1 = ADDR_W + 1;
   localparam logic [AW1-1:0] C_DLINE = AW1'(LINE_W);
   localparam logic [AW1-1:0] C_DONE1 = AW1'(1);

   logic [AW1-1:0] r_dcnt;

   assign w_rd_drn = !flush && (r_state == S_DRAIN) &&
                     (r_dcnt < C_DLINE) && w_room;
`else
   assign w_rd_drn = 1'b0;
`endif

   // Credit check: entries held plus the read in flight, minus this cycle's pop.
   assign w_pop  = !flush && (r_fcnt != 2'd0) && out_ready;
   assign w_push = !flush && r_rd_pend;
   assign w_occ  = {1'b0, r_fcnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
   assign w_room = (w_occ < 3'd2);

   assign w_fill      = (r_state == S_FILL);
   assign w_steady    = (r_state == S_STEADY);
   assign w_frame_end = (r_cnt == C_FRAME);
   assign w_fifo_idle = (r_fcnt == 2'd0) && !r_rd_pend;

   assign w_in_rdy  = !flush &&
                      (w_fill || (w_steady && !w_frame_end && w_room));
   assign w_acc     = in_valid && w_in_rdy;
   assign w_rd_stdy = w_acc && w_steady;
   assign w_ren     = w_rd_stdy || w_rd_drn;
   assign w_wptr_nx = (r_wptr == C_WLAST) ? '0 : r_wptr + C_AONE;

   assign in_ready   = w_in_rdy;
   assign sram_wen   = w_acc;
   assign sram_waddr = w_acc ? r_wptr : '0;
   assign sram_wdata = w_acc ? in_data : '0;
   assign sram_ren   = w_ren;
   assign sram_raddr = w_ren ? r_wptr : '0;
   assign out_valid  = !flush && (r_fcnt != 2'd0);
   assign out_data   = out_valid ? r_fifo[r_frd] : '0;
   assign busy       = !flush && r_busy;
   assign done       = !flush && r_done;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_fwr] <= sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         r_state   <= S_IDLE;
         r_wptr    <= '0;
         r_cnt     <= '0;
         r_rd_pend <= 1'b0;
         r_fwr     <= 1'b0;
         r_frd     <= 1'b0;
         r_fcnt    <= 2'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
         r_dcnt    <= '0;
`endif
      end else begin
         r_rd_pend <= w_ren;
         r_fcnt    <= r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_push) begin
            r_fwr <= ~r_fwr;
         end
         if (w_pop) begin
            r_frd <= ~r_frd;
         end
         // In DRAIN the write pointer doubles as the read pointer.
         if (w_acc || w_rd_drn) begin
            r_wptr <= w_wptr_nx;
         end
         if (w_acc) begin
            r_cnt <= r_cnt + C_CONE;
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_FILL;
                  r_wptr  <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_FILL: begin
               if (w_acc && (r_cnt == C_LLAST)) begin
                  r_state <= S_STEADY;
               end
            end
            S_STEADY: begin
               if (w_frame_end) begin
`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
                  r_state <= S_DRAIN;
                  r_dcnt  <= '0;
`else
                  if (w_fifo_idle) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
`endif
               end
            end
`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
            S_DRAIN: begin
               if (w_rd_drn) begin
                  r_dcnt <= r_dcnt + C_DONE1;
               end
               if ((r_dcnt == C_DLINE) && w_fifo_idle) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
`endif
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lake_linebuf_ctrl.sv
// Directed scoreboard bench for lake_linebuf_ctrl: LINE_W=4/FRAME_PIX=16 and LINE_W=1/FRAME_PIX=3.
`timescale 1ns/1ps
module tb_lake_linebuf_ctrl;

   localparam int DW = 16;
   localparam int AW = 16;
`ifdef LAKE_LINEBUF_CTRL_DRAIN_EN
   localparam int DRN = 1;
`else
   localparam int DRN = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          a_flush, a_start, a_in_valid, a_in_ready;
   logic [DW-1:0] a_in_data, a_out_data, a_wdata, a_rdata;
   logic          a_out_valid, a_out_ready, a_wen, a_ren, a_busy, a_done;
   logic [AW-1:0] a_waddr, a_raddr;

   logic          b_flush, b_start, b_in_valid, b_in_ready;
   logic [DW-1:0] b_in_data, b_out_data, b_wdata, b_rdata;
   logic          b_out_valid, b_out_ready, b_wen, b_ren, b_busy, b_done;
   logic [AW-1:0] b_waddr, b_raddr;

   lake_linebuf_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LINE_W(4), .FRAME_PIX(16)) u_a (
      .clk(clk), .flush(a_flush), .start(a_start),
      .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
      .sram_wen(a_wen), .sram_waddr(a_waddr), .sram_wdata(a_wdata),
      .sram_ren(a_ren), .sram_raddr(a_raddr), .sram_rdata(a_rdata),
      .busy(a_busy), .done(a_done));

   lake_linebuf_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LINE_W(1), .FRAME_PIX(3)) u_b (
      .clk(clk), .flush(b_flush), .start(b_start),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .sram_wen(b_wen), .sram_waddr(b_waddr), .sram_wdata(b_wdata),
      .sram_ren(b_ren), .sram_raddr(b_raddr), .sram_rdata(b_rdata),
      .busy(b_busy), .done(b_done));

   // Read-first SRAM models with one cycle read latency.
   logic [DW-1:0] mem_a [16];
   logic [DW-1:0] mem_b [16];
   always @(posedge clk) begin
      if (a_ren) a_rdata <= mem_a[a_raddr[3:0]];
      if (a_wen) mem_a[a_waddr[3:0]] <= a_wdata;
      if (b_ren) b_rdata <= mem_b[b_raddr[3:0]];
      if (b_wen) mem_b[b_waddr[3:0]] <= b_wdata;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   logic [DW-1:0] q_a [$];
   logic [DW-1:0] q_b [$];
   int wp_a, acc_a, out_a, done_a, stall_a;
   int acc5_edge, first_out_a, last_out_a, done_cyc_a;
   int out_b, done_b;
   bit tog;

   always @(negedge clk) begin
      if (a_in_valid && a_in_ready) begin
         chk("a_wen", a_wen, 1);
         chk("a_waddr", a_waddr, wp_a);
         chk("a_wdata", a_wdata, a_in_data);
         chk("a_ren", a_ren, acc_a >= 4);
         if (acc_a >= 4) chk("a_raddr", a_raddr, wp_a);
         q_a.push_back(a_in_data);
         wp_a = (wp_a + 1) % 4;
         acc_a++;
         if (acc_a == 5) acc5_edge = cyc + 1;
      end
      if (a_out_valid && a_out_ready) begin
         chk("a_q_nonempty", q_a.size() != 0, 1);
         if (q_a.size() != 0) chk("a_out_data", a_out_data, q_a.pop_front());
         if (out_a == 0) first_out_a = cyc;
         last_out_a = cyc;
         out_a++;
      end
      if (a_busy && a_in_valid && !a_in_ready) stall_a++;
      if (a_done) begin
         done_a++;
         done_cyc_a = cyc;
      end
      if (b_in_valid && b_in_ready) begin
         chk("b_waddr", b_waddr, 0);
         q_b.push_back(b_in_data);
      end
      if (b_ren) chk("b_raddr", b_raddr, 0);
      if (b_out_valid && b_out_ready) begin
         chk("b_q_nonempty", q_b.size() != 0, 1);
         if (q_b.size() != 0) chk("b_out_data", b_out_data, q_b.pop_front());
         out_b++;
      end
      if (b_done) done_b++;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         a_out_ready = tog ? ~a_out_ready : 1'b1;
      end
   end

   task automatic reset_model_a();
      q_a.delete();
      wp_a = 0; acc_a = 0; out_a = 0; done_a = 0; stall_a = 0;
      acc5_edge = -1; first_out_a = -1; last_out_a = -1; done_cyc_a = -1;
   endtask

   task automatic send_a(input int v);
      bit acc = 1'b0;
      int n = 0;
      a_in_valid = 1'b1;
      a_in_data  = DW'(v);
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = a_in_ready;
         n++;
         @(posedge clk);
         #1;
      end
      a_in_valid = 1'b0;
      if (!acc) chk("a_send_timeout", acc, 1);
   endtask

   task automatic send_b(input int v);
      bit acc = 1'b0;
      int n = 0;
      b_in_valid = 1'b1;
      b_in_data  = DW'(v);
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = b_in_ready;
         n++;
         @(posedge clk);
         #1;
      end
      b_in_valid = 1'b0;
      if (!acc) chk("b_send_timeout", acc, 1);
   endtask

   task automatic wait_done_a(input int budget);
      bit seen = 1'b0;
      int n = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         seen = a_done;
         n++;
      end
      chk("a_done_seen", seen, 1);
   endtask

   task automatic pulse_start_a();
      a_start = 1'b1;
      @(posedge clk);
      #1;
      a_start = 1'b0;
   endtask

   task automatic frame_end_checks_a(input string tag);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({tag, "_outs"}, out_a, DRN ? 16 : 12);
      chk({tag, "_left"}, q_a.size(), DRN ? 0 : 4);
      chk({tag, "_done_cnt"}, done_a, 1);
      chk({tag, "_done_after_last"}, done_cyc_a > last_out_a, 1);
      chk({tag, "_busy_idle"}, a_busy, 0);
   endtask

   initial begin
      a_flush = 1'b1; a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
      b_flush = 1'b1; b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
      a_out_ready = 1'b1; b_out_ready = 1'b1; tog = 1'b0;
      out_b = 0; done_b = 0;
      reset_model_a();

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_wen", a_wen, 0);
      chk("rst_ren", a_ren, 0);
      chk("rst_out_data", a_out_data, 0);
      @(posedge clk);
      #1;
      a_flush = 1'b0;
      b_flush = 1'b0;
      a_in_valid = 1'b1;
      a_in_data  = 16'h55;
      @(negedge clk);
      chk("idle_in_ready", a_in_ready, 0);
      chk("idle_wen", a_wen, 0);
      chk("idle_waddr", a_waddr, 0);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;

      // Frame 1: back-to-back input, downstream always ready.
      reset_model_a();
      pulse_start_a();
      for (int v = 1; v <= 16; v++) send_a(v);
      wait_done_a(200);
      frame_end_checks_a("f1");
      chk("f1_latency", first_out_a, acc5_edge + 1);
      chk("f1_back_to_back", last_out_a - first_out_a, out_a - 1);

      // Frame 2: out_ready toggles, plus a stray start while in STEADY.
      reset_model_a();
      tog = 1'b1;
      pulse_start_a();
      for (int v = 1; v <= 8; v++) send_a(v);
      a_start = 1'b1;
      send_a(9);
      a_start = 1'b0;
      for (int v = 10; v <= 16; v++) send_a(v);
      wait_done_a(400);
      frame_end_checks_a("f2");
      chk("f2_stalled", stall_a != 0, 1);
      tog = 1'b0;
      @(posedge clk);
      #1;

      // Flush in STEADY while a read is in flight, then restart.
      reset_model_a();
      pulse_start_a();
      for (int v = 1; v <= 6; v++) send_a(v);
      a_flush = 1'b1;
      @(negedge clk);
      chk("fl_during_out_valid", a_out_valid, 0);
      chk("fl_during_busy", a_busy, 0);
      chk("fl_during_ren", a_ren, 0);
      @(posedge clk);
      #1;
      a_flush = 1'b0;
      reset_model_a();
      @(negedge clk);
      chk("fl_after_out_valid", a_out_valid, 0);
      chk("fl_after_busy", a_busy, 0);
      chk("fl_after_in_ready", a_in_ready, 0);
      @(posedge clk);
      #1;
      pulse_start_a();
      for (int v = 1; v <= 8; v++) send_a(v);
      repeat (6) @(posedge clk);
      #1;
      chk("fl_restart_outs", out_a, 4);
      chk("fl_restart_left", q_a.size(), 4);
      a_flush = 1'b1;
      @(posedge clk);
      #1;
      a_flush = 1'b0;

      // Single-pixel line on the second instance.
      b_start = 1'b1;
      @(posedge clk);
      #1;
      b_start = 1'b0;
      send_b(7);
      send_b(8);
      send_b(9);
      begin
         bit seen = 1'b0;
         int n = 0;
         while (!seen && n < 100) begin
            @(negedge clk);
            seen = b_done;
            n++;
         end
         chk("b_done_seen", seen, 1);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("b_outs", out_b, DRN ? 3 : 2);
      chk("b_left", q_b.size(), DRN ? 0 : 1);
      chk("b_done_cnt", done_b, 1);
      chk("b_busy_idle", b_busy, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
